// File: rtl/wb_arb5.sv
// Round-robin arbiter for five Wishbone masters. It drives a registered one-hot grant.
// A hold watchdog revokes the grant from a master that stalls without an acknowledge.
module wb_arb5 #(
    parameter int unsigned MAX_HOLD = 1024,
    parameter int unsigned CNT_W    = 11
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [4:0] req,
    input  logic       ack,
    output logic [4:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] gnt_id,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_n;
    logic [2:0]       last, last_n;
    logic [4:0]       mask, mask_n;
    logic [CNT_W-1:0] hold_cnt, cnt_n;
    logic [4:0]       gnt_n;
    logic             valid_n;
    logic [2:0]       id_n;
    logic             timeout_n;

    logic [4:0] elig;
    logic [2:0] base;
    logic [2:0] start;
    logic       pick_found;
    logic [2:0] pick_idx;
    logic       hold_expired;

    assign elig = req & ~mask;

    // In BUSY the search base is the current owner; that owner becomes "last" on release.
    assign base  = (state == BUSY) ? gnt_id : last;
    assign start = (base >= 3'd4) ? 3'd0 : base + 3'd1;

    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            idx = int'(start) + k;
            if (idx >= 5) idx = idx - 5;
            if (!pick_found && elig[idx]) begin
                pick_found = 1'b1;
                pick_idx   = 3'(idx);
            end
        end
    end

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        valid_n   = gnt_valid;
        id_n      = gnt_id;
        timeout_n = 1'b0;
        last_n    = last;
        cnt_n     = hold_cnt;
        mask_n    = mask & req;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_n   = 5'd1 << pick_idx;
                    id_n    = pick_idx;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = BUSY;
                end else begin
                    gnt_n   = 5'd0;
                    valid_n = 1'b0;
                end
            end
            BUSY: begin
                if (!req[gnt_id]) begin
                    last_n = gnt_id;
                    cnt_n  = '0;
                    if (pick_found) begin
                        gnt_n = 5'd1 << pick_idx;
                        id_n  = pick_idx;
                    end else begin
                        gnt_n   = 5'd0;
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end else if (ack) begin
                    cnt_n = '0;
                end else if (hold_expired) begin
                    gnt_n          = 5'd0;
                    valid_n        = 1'b0;
                    timeout_n      = 1'b1;
                    mask_n[gnt_id] = 1'b1;
                    last_n         = gnt_id;
                    cnt_n          = '0;
                    state_n        = IDLE;
                end else if (hold_cnt != CNT_MAX) begin
                    cnt_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            gnt       <= 5'd0;
            gnt_valid <= 1'b0;
            gnt_id    <= 3'd0;
            timeout   <= 1'b0;
            last      <= 3'd4;
            mask      <= 5'd0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_valid <= valid_n;
            gnt_id    <= id_n;
            timeout   <= timeout_n;
            last      <= last_n;
            mask      <= mask_n;
            hold_cnt  <= cnt_n;
        end
    end

endmodule

// File: tb/tb_wb_arb5.sv
// Directed bench for wb_arb5 with MAX_HOLD=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_wb_arb5;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic       ack;
    logic [4:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic       timeout;

    int unsigned n_tests;
    int unsigned n_fail;

    wb_arb5 #(.MAX_HOLD(8), .CNT_W(11)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .req      (req),
        .ack      (ack),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input int unsigned id);
        check({tag, " gnt"}, gnt, 32'd1 << id);
        check({tag, " gnt_id"}, gnt_id, id);
        check({tag, " gnt_valid"}, gnt_valid, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int unsigned seq [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        req = 5'd0;
        ack = 1'b0;

        // Reset values, then a single request granted one cycle later.
        step();
        step();
        check("rst gnt", gnt, 0);
        check("rst gnt_valid", gnt_valid, 0);
        check("rst gnt_id", gnt_id, 0);
        check("rst timeout", timeout, 0);
        rst = 1'b0;
        req = 5'b00001;
        step();
        check_grant("single", 0);
        req = 5'b00000;
        step();
        check("single release gnt", gnt, 0);
        check("single release valid", gnt_valid, 0);

        // Full rotation with back-to-back handovers.
        do_reset();
        req = 5'b11111;
        step();
        foreach (seq[s]) begin
            check_grant($sformatf("rr%0d", s), seq[s]);
            for (int c = 0; c < 2; c++) begin
                step();
                check_grant($sformatf("rr%0d hold", s), seq[s]);
            end
            step();
            req[seq[s]] = 1'b0;
            step();
            check($sformatf("rr%0d no gap", s), gnt_valid, 1);
            req[seq[s]] = 1'b1;
        end
        req = 5'b00000;
        step();
        step();
        check("rr idle gnt", gnt, 0);

        // Release from master 2 while 0,1,4 request: order 4, 0, 1.
        do_reset();
        req = 5'b00100;
        step();
        check_grant("m2", 2);
        step();
        req = 5'b10011;
        step();
        check_grant("after2", 4);
        req = 5'b00011;
        step();
        check_grant("after4", 0);
        req = 5'b00010;
        step();
        check_grant("after0", 1);
        req = 5'b00000;
        step();
        check("m2 seq idle", gnt_valid, 0);

        // Watchdog: master 1 stalls with no ack.
        req = 5'b00010;
        step();
        for (int c = 0; c < 8; c++) begin
            check_grant($sformatf("wd hold%0d", c), 1);
            check($sformatf("wd to%0d", c), timeout, 0);
            step();
        end
        check("wd revoke gnt", gnt, 0);
        check("wd revoke valid", gnt_valid, 0);
        check("wd pulse", timeout, 1);
        step();
        check("wd pulse end", timeout, 0);
        check("wd masked gnt", gnt, 0);
        step();
        step();
        check("wd still masked", gnt, 0);
        req = 5'b00000;
        step();
        req = 5'b00010;
        step();
        check_grant("wd regrant", 1);

        // Periodic ack keeps the grant alive.
        for (int c = 0; c < 100; c++) begin
            ack = (c % 5 == 4);
            step();
            check($sformatf("ack gnt%0d", c), gnt, 5'b00010);
            check($sformatf("ack to%0d", c), timeout, 0);
        end
        ack = 1'b0;
        req = 5'b00000;
        step();
        check("ack idle", gnt_valid, 0);

        // Ack on the threshold cycle beats the watchdog.
        req = 5'b00010;
        step();
        for (int c = 0; c < 7; c++) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_grant("ack wins", 1);
        check("ack wins to", timeout, 0);
        step();
        check("ack wins next to", timeout, 0);
        req = 5'b00000;
        step();

        // Reset while master 3 holds the bus; master 0 wins afterwards.
        req = 5'b01000;
        step();
        check_grant("m3", 3);
        step();
        rst = 1'b1;
        step();
        check("midrst gnt", gnt, 0);
        check("midrst valid", gnt_valid, 0);
        check("midrst id", gnt_id, 0);
        rst = 1'b0;
        req = 5'b01001;
        step();
        check_grant("post rst", 0);
        req = 5'b00000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arb5.md
Name: wb_arb5

Overview:
- Round-robin bus arbiter for five Wishbone masters sharing one slave path.
- Produces the registered one-hot grant vector that drives the downstream 32-bit five-input data select.
- Holds the grant for the whole master cycle.
- Has a hold watchdog that forcibly revokes a grant from a master stalled without acknowledge.

Parameters:
- MAX_HOLD, 1024: max consecutive grant cycles without ack before forced release; 0 disables the watchdog.
- CNT_W, 11: hold counter width; MAX_HOLD must be < 2^CNT_W.

Ports:
- wb_clk_i  in  1  system clock, all logic on rising edge
- wb_rst_i  in  1  synchronous reset, active-high
- req  in  5  per-master cycle request (cyc_o of master i on bit i)
- ack  in  1  slave ack or err for the currently granted master
- gnt  out  5  registered one-hot grant, or all-zero
- gnt_valid  out  1  OR of gnt, registered
- gnt_id  out  3  binary index of granted master, 0..4; holds last value when gnt_valid=0
- timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, timeout=0, state=IDLE, last=4 (master 0 has top priority first), hold_cnt=0, mask=0.
- Eligible set: elig = req & ~mask.
- Round-robin pick: search elig starting at index last+1 (mod 5), wrapping. The first set bit wins.
- gnt is always one-hot or zero; never two bits set.
- IDLE:
  - If elig≠0, then at the next edge: gnt=onehot(pick), gnt_id=pick, gnt_valid=1, hold_cnt=0, state→BUSY.
  - Latency from req rising to gnt is exactly 1 cycle.
  - If elig=0, stay in IDLE with gnt=0.
- BUSY, cur=gnt_id:
  - Normal hold: req[cur]=1 and no timeout → gnt unchanged.
    - hold_cnt clears on ack, else increments.
  - Release: req[cur]=0 → last=cur.
    - The new pick is computed this cycle from elig with search starting at cur+1; req[cur] is already 0.
    - If pick exists: at the next edge gnt=onehot(pick), hold_cnt=0, stay BUSY. This is a back-to-back handover with no dead cycle.
    - Otherwise: gnt=0, gnt_valid=0, state→IDLE.
  - Timeout: MAX_HOLD≠0 and req[cur]=1 and ack=0 and hold_cnt==MAX_HOLD-1. At the next edge:
    - gnt=0, gnt_valid=0, timeout=1 for one cycle, mask[cur]=1, last=cur, state→IDLE.
    - Net effect: with ack never asserted, gnt stays high exactly MAX_HOLD cycles.
  - Simultaneous ack and the timeout threshold: ack wins; the counter clears and there is no timeout.
- Mask:
  - mask[i] clears on any edge where req[i]=0.
  - A masked master is not re-granted until it deasserts and re-asserts req.
  - Masking never blocks other masters.
- Reset mid-grant: at the reset edge all state returns to reset values. gnt is 0 in the following cycle regardless of req/ack.
- hold_cnt saturates at 2^CNT_W-1 when MAX_HOLD=0; no wrap.
- A req change on a non-granted bit during BUSY has no effect until the next release.

Test Plan:
- Reset, then req=5'b00001 → next cycle gnt=5'b00001, gnt_id=0, gnt_valid=1; all outputs are 0 during reset.
- req=5'b11111, each granted master drops its req 3 cycles after grant and re-raises it next cycle.
  - Required grant sequence: 0,1,2,3,4,0.
  - Handovers happen with no cycle where gnt=0.
- Master 2 granted, req becomes 5'b10011 as bit 2 drops → next gnt=5'b10000 (id 4), then 0, then 1 on subsequent releases.
- MAX_HOLD=8, master 1 holds req with ack=0.
  - gnt high exactly 8 cycles, then gnt=0 and timeout=1 for one cycle.
  - With req[1] held high, no re-grant.
  - After req[1] drops for one cycle and rises again → re-granted.
- MAX_HOLD=8, ack pulsed every 5th cycle for 100 cycles → timeout never asserts, grant held throughout.
- Assert wb_rst_i while master 3 is granted → gnt=0 the next cycle.
  - After reset release with req=5'b01001, the first grant goes to master 0, because last resets to 4.
